// File: rtl/road_scroll_controller.sv
// Per-frame road background scroll engine: key-driven speed, fixed-point
// position wrapping on the background period, and a saturating wrap counter.
module road_scroll_controller #(
    parameter int FRAC_BITS    = 4,
    parameter int PERIOD_LINES = 64,
    parameter int MAX_SPEED    = 48,
    parameter int ACCEL_STEP   = 1,
    parameter int BRAKE_STEP   = 4,
    parameter int DRAG_STEP    = 1,
    parameter int DRAG_FRAMES  = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        startOfFrame,
    input  logic        accel_key,
    input  logic        brake_key,
    input  logic        pause_key,
    output logic [31:0] y_offset,
    output logic [7:0]  speed,
    output logic [2:0]  state,
    output logic [15:0] distance,
    output logic        wrap_pulse
);

    localparam int POS_W = $clog2(PERIOD_LINES) + FRAC_BITS;
    localparam int DCW   = $clog2(DRAG_FRAMES + 1);
    localparam logic [POS_W:0] WRAP_VAL = (POS_W + 1)'(PERIOD_LINES << FRAC_BITS);

    typedef enum logic [2:0] {
        ST_STOPPED = 3'd0,
        ST_ACCEL   = 3'd1,
        ST_CRUISE  = 3'd2,
        ST_COAST   = 3'd3,
        ST_BRAKE   = 3'd4,
        ST_PAUSED  = 3'd5
    } state_t;

    state_t           st;
    logic [POS_W-1:0] pos;
    logic [DCW-1:0]   drag_cnt;

    logic [POS_W:0]   pos_sum;
    logic             wrapped;
    logic [POS_W-1:0] pos_next;
    logic [8:0]       spd_up;
    logic [7:0]       spd_brake;
    logic [7:0]       spd_accel;
    logic [7:0]       spd_drag;
    logic             drag_hit;

    always_comb begin
        pos_sum  = {1'b0, pos} + (POS_W + 1)'(speed);
        wrapped  = (pos_sum >= WRAP_VAL);
        pos_next = wrapped ? POS_W'(pos_sum - WRAP_VAL) : POS_W'(pos_sum);

        spd_brake = (speed >= 8'(BRAKE_STEP)) ? (speed - 8'(BRAKE_STEP)) : 8'd0;
        spd_up    = {1'b0, speed} + 9'(ACCEL_STEP);
        spd_accel = (spd_up >= 9'(MAX_SPEED)) ? 8'(MAX_SPEED) : spd_up[7:0];
        spd_drag  = (speed >= 8'(DRAG_STEP)) ? (speed - 8'(DRAG_STEP)) : 8'd0;
        drag_hit  = (drag_cnt == DCW'(DRAG_FRAMES - 1));
    end

    // Keys only matter on the frame strobe; everything else holds in between.
    always_ff @(posedge clk) begin
        if (reset) begin
            st         <= ST_STOPPED;
            pos        <= '0;
            speed      <= '0;
            y_offset   <= '0;
            distance   <= '0;
            drag_cnt   <= '0;
            wrap_pulse <= 1'b0;
        end else begin
            wrap_pulse <= 1'b0;
            if (startOfFrame) begin
                if (pause_key) begin
                    st <= ST_PAUSED;
                end else begin
                    pos      <= pos_next;
                    y_offset <= 32'(pos_next[POS_W-1:FRAC_BITS]);
                    if (wrapped) begin
                        wrap_pulse <= 1'b1;
                        if (distance != 16'hFFFF)
                            distance <= distance + 16'd1;
                    end

                    if (brake_key) begin
                        speed    <= spd_brake;
                        drag_cnt <= '0;
                        st       <= (spd_brake == 8'd0) ? ST_STOPPED : ST_BRAKE;
                    end else if (accel_key) begin
                        speed    <= spd_accel;
                        drag_cnt <= '0;
                        st       <= (spd_accel == 8'(MAX_SPEED)) ? ST_CRUISE : ST_ACCEL;
                    end else if (drag_hit) begin
                        speed    <= spd_drag;
                        drag_cnt <= '0;
                        st       <= (spd_drag == 8'd0) ? ST_STOPPED : ST_COAST;
                    end else begin
                        drag_cnt <= drag_cnt + DCW'(1);
                        st       <= (speed == 8'd0) ? ST_STOPPED : ST_COAST;
                    end
                end
            end
        end
    end

    assign state = st;

endmodule

// File: tb/tb_road_scroll_controller.sv
// Directed self-checking bench for road_scroll_controller with hand-computed
// expectations for acceleration, wrap, braking, pause, drag and reset.
module tb_road_scroll_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic        startOfFrame;
    logic        accel_key;
    logic        brake_key;
    logic        pause_key;
    logic [31:0] y_offset;
    logic [7:0]  speed;
    logic [2:0]  state;
    logic [15:0] distance;
    logic        wrap_pulse;

    int checks   = 0;
    int failures = 0;
    int wraps;
    int wrap_frame;
    int idle_wraps;

    road_scroll_controller dut (
        .clk          (clk),
        .reset        (reset),
        .startOfFrame (startOfFrame),
        .accel_key    (accel_key),
        .brake_key    (brake_key),
        .pause_key    (pause_key),
        .y_offset     (y_offset),
        .speed        (speed),
        .state        (state),
        .distance     (distance),
        .wrap_pulse   (wrap_pulse)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One frame strobe; outputs are sampled 1 time unit after the edge that
    // consumed it, so wrap_pulse is still visible on return.
    task automatic frame(input logic a, input logic b, input logic p);
        accel_key    = a;
        brake_key    = b;
        pause_key    = p;
        startOfFrame = 1'b1;
        @(posedge clk);
        #1;
        startOfFrame = 1'b0;
        if (wrap_pulse) begin
            wraps++;
        end
    endtask

    task automatic gap();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        wraps = 0;
    endtask

    initial begin
        reset = 1'b1; startOfFrame = 1'b0;
        accel_key = 1'b0; brake_key = 1'b0; pause_key = 1'b0;
        wraps = 0; wrap_frame = -1; idle_wraps = 0;

        do_reset();
        chk("rst_y", int'(y_offset), 0);
        chk("rst_speed", int'(speed), 0);
        chk("rst_state", int'(state), 0);
        chk("rst_dist", int'(distance), 0);

        // 10 accel frames: speed 10, pos 45 -> y 2
        for (int i = 0; i < 10; i++) begin
            frame(1'b1, 1'b0, 1'b0);
            gap();
        end
        chk("acc10_speed", int'(speed), 10);
        chk("acc10_y", int'(y_offset), 2);
        chk("acc10_state", int'(state), 1);
        chk("acc10_wraps", wraps, 0);

        // No strobe for 1000 cycles while keys toggle
        for (int i = 0; i < 1000; i++) begin
            accel_key = 1'(i % 2);
            brake_key = 1'((i / 3) % 2);
            pause_key = 1'((i / 7) % 2);
            @(posedge clk);
            #1;
            if (wrap_pulse) idle_wraps++;
        end
        chk("idle_wraps", idle_wraps, 0);
        chk("idle_y", int'(y_offset), 2);
        chk("idle_speed", int'(speed), 10);
        chk("idle_state", int'(state), 1);
        chk("idle_dist", int'(distance), 0);

        // 60 accel frames from reset: wrap at frame 46, CRUISE at 48
        do_reset();
        for (int i = 1; i <= 60; i++) begin
            frame(1'b1, 1'b0, 1'b0);
            if (wrap_pulse && wrap_frame < 0) wrap_frame = i;
            if (i == 46) begin
                chk("f46_y", int'(y_offset), 0);
                chk("f46_dist", int'(distance), 1);
            end
            if (i == 47) chk("f47_state", int'(state), 1);
            if (i == 48) begin
                chk("f48_speed", int'(speed), 48);
                chk("f48_state", int'(state), 2);
            end
            gap();
            if (i == 46) chk("f46_pulse_width", int'(wrap_pulse), 0);
        end
        chk("acc60_wrap_frame", wrap_frame, 46);
        chk("acc60_wraps", wraps, 1);
        chk("acc60_speed", int'(speed), 48);
        chk("acc60_state", int'(state), 2);
        chk("acc60_y", int'(y_offset), 42);

        // Brake 7 frames: 48 -> 20, then accel+brake -> 16
        for (int i = 0; i < 7; i++) begin
            frame(1'b0, 1'b1, 1'b0);
            gap();
        end
        chk("brk_speed20", int'(speed), 20);
        chk("brk_state20", int'(state), 4);
        frame(1'b1, 1'b1, 1'b0);
        chk("both_speed", int'(speed), 16);
        chk("both_state", int'(state), 4);
        gap();

        // Speed 2 then brake -> STOPPED
        do_reset();
        frame(1'b1, 1'b0, 1'b0); gap();
        frame(1'b1, 1'b0, 1'b0); gap();
        chk("spd2_speed", int'(speed), 2);
        frame(1'b0, 1'b1, 1'b0);
        chk("stop_speed", int'(speed), 0);
        chk("stop_state", int'(state), 0);
        gap();

        // Speed 30 (pos 435, y 27), pause 5 frames, then coast
        do_reset();
        for (int i = 0; i < 30; i++) begin
            frame(1'b1, 1'b0, 1'b0);
            gap();
        end
        chk("acc30_speed", int'(speed), 30);
        chk("acc30_y", int'(y_offset), 27);
        for (int i = 0; i < 5; i++) begin
            frame(1'b1, 1'b1, 1'b1);
            chk("pause_y", int'(y_offset), 27);
            chk("pause_speed", int'(speed), 30);
            chk("pause_dist", int'(distance), 0);
            chk("pause_state", int'(state), 5);
            gap();
        end
        for (int i = 1; i <= 8; i++) begin
            frame(1'b0, 1'b0, 1'b0);
            chk("coast_state", int'(state), 3);
            chk("coast_speed", int'(speed), (i == 8) ? 29 : 30);
            gap();
        end
        // pos 435+8*30 = 675 -> y 42
        chk("coast_y", int'(y_offset), 42);

        // Hold around speed 30 until three wraps accumulate
        frame(1'b1, 1'b0, 1'b0); gap();
        for (int n = 0; n < 60 && distance < 16'd3; n++) begin
            for (int i = 0; i < 8; i++) begin
                frame(1'b0, 1'b0, 1'b0);
                gap();
            end
            frame(1'b1, 1'b0, 1'b0);
            gap();
        end
        chk("pre_rst_speed", int'(speed), 30);
        chk("pre_rst_dist", int'(distance), 3);

        // Reset wins over a concurrent frame strobe
        reset = 1'b1;
        startOfFrame = 1'b1; accel_key = 1'b1;
        @(posedge clk);
        #1;
        startOfFrame = 1'b0; accel_key = 1'b0;
        chk("mid_rst_y", int'(y_offset), 0);
        chk("mid_rst_speed", int'(speed), 0);
        chk("mid_rst_dist", int'(distance), 0);
        chk("mid_rst_state", int'(state), 0);
        chk("mid_rst_pulse", int'(wrap_pulse), 0);
        reset = 1'b0;
        gap();
        frame(1'b0, 1'b0, 1'b0);
        chk("post_rst_state", int'(state), 0);
        chk("post_rst_speed", int'(speed), 0);
        gap();
        frame(1'b1, 1'b0, 1'b0);
        chk("post_rst_acc_speed", int'(speed), 1);
        chk("post_rst_acc_y", int'(y_offset), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/road_scroll_controller.md
Name: road_scroll_controller

Overview:
Per-frame vertical scroll engine for the road background. It sits directly upstream of the sprite storage / bitmap stage and drives that stage's y_offset input. It converts player key inputs into a speed and a fixed-point position, then outputs an integer scroll offset that wraps on the 64-line background period. It also counts completed wraps as travelled distance for the HUD and score logic.

Parameters:
FRAC_BITS, 4, fractional bits of speed and position (speed unit = 1/16 px per frame)
PERIOD_LINES, 64, background vertical period in lines; must be a power of 2
MAX_SPEED, 48, speed ceiling in fractional units (3 px/frame)
ACCEL_STEP, 1, speed increase per frame while accelerating
BRAKE_STEP, 4, speed decrease per frame while braking
DRAG_STEP, 1, speed decrease applied once per DRAG_FRAMES coasting frames
DRAG_FRAMES, 8, number of coasting frames per drag application

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
startOfFrame  in  1  one-cycle pulse per video frame; all updates are keyed to it
accel_key  in  1  level, accelerate request
brake_key  in  1  level, brake request
pause_key  in  1  level, freeze request
y_offset  out  32 (int)  scroll offset in lines, range 0..PERIOD_LINES-1
speed  out  8  current speed, fractional units
state  out  3  STOPPED=0, ACCEL=1, CRUISE=2, COAST=3, BRAKE=4, PAUSED=5
distance  out  16  completed background wraps, saturating
wrap_pulse  out  1  one-cycle pulse when position wraps

Behaviour:
- Reset (synchronous, high, wins over everything): pos=0, speed=0, y_offset=0, distance=0, wrap_pulse=0, drag_cnt=0, state=STOPPED.
- Outside startOfFrame cycles, all registers hold. wrap_pulse is 0 in every cycle except the update cycle below.
- All outputs update on the clk edge that samples startOfFrame=1 (1-cycle latency). Keys are sampled only on that edge.
- Internal pos register: width log2(PERIOD_LINES)+FRAC_BITS (10 bits at defaults), range 0..1023.
- Key priority: pause > brake > accel > none. accel and brake together are treated as brake.
- Per-frame update, using old speed S:
  - PAUSED (pause_key=1): pos, speed, distance, drag_cnt all unchanged.
  - Otherwise pos advances by S. If pos+S >= PERIOD_LINES<<FRAC_BITS, subtract that value, set wrap_pulse=1 for one cycle, and increment distance (saturate at 65535).
- Speed update, not paused:
  - brake: S'=max(S-BRAKE_STEP,0).
  - accel only: S'=min(S+ACCEL_STEP,MAX_SPEED).
  - none: drag_cnt++; when drag_cnt reaches DRAG_FRAMES, S'=max(S-DRAG_STEP,0) and drag_cnt clears. Otherwise S'=S.
  - drag_cnt clears on any frame that is not coasting.
- Next state after a frame:
  - pause -> PAUSED.
  - brake -> BRAKE, or STOPPED if S'=0.
  - accel -> CRUISE if S'=MAX_SPEED, else ACCEL.
  - none -> COAST, or STOPPED if S'=0.
- y_offset = pos >> FRAC_BITS, zero-extended. Registered with the same edge as pos.
- Releasing pause resumes from the held values. There is no catch-up for the paused frames.
- Width/arithmetic: speed sums are computed 9 bits wide before saturation, so there is no 8-bit overflow. Position addition is computed 11 bits wide before the wrap compare.

Test Plan:
- Reset asserted mid-run at speed 30, distance 3 -> next edge: y_offset=0, speed=0, distance=0, state=0; a startOfFrame during reset is ignored.
- accel_key held for 10 frames from reset -> speed=10, pos=45, y_offset=2, state=ACCEL; no wrap_pulse.
- accel_key held for 60 frames -> wrap_pulse on frame 46 (pos 1035-1024=11), distance=1; speed reaches 48 on frame 48, state=CRUISE; speed holds at 48 afterwards.
- At speed 20, accel_key and brake_key together for 1 frame -> speed=16, state=BRAKE. At speed 2, brake for 1 frame -> speed=0, state=STOPPED.
- At speed 30, pause_key for 5 frames -> y_offset/speed/distance frozen, state=PAUSED. Then no keys -> state=COAST, speed stays 30 for 7 frames and becomes 29 on the 8th coasting frame.
- startOfFrame held low for 1000 cycles with keys toggling -> all outputs unchanged, wrap_pulse never asserted.
